// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer for the RV64I ALU: registers the ALU operands, runs the
// memory request/response handshake for loads and stores, then commits or traps.
module alu_exec_sequencer #(
  parameter int XLEN        = 64,
  parameter int OPG_W       = 4,
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [OPG_W-1:0] issue_op_group_i,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic [XLEN-1:0]  issue_rs1_i,
  input  logic [XLEN-1:0]  issue_rs2_i,
  input  logic [XLEN-1:0]  issue_pc_i,
  input  logic [11:0]      issue_imm_i,
  input  logic [19:0]      issue_uimm_i,
  input  logic [4:0]       issue_rd_idx_i,
  input  logic             issue_wb_en_i,
  output logic [OPG_W-1:0] alu_op_group_o,
  output logic [OP_W-1:0]  alu_op_o,
  output logic [XLEN-1:0]  alu_rs1_o,
  output logic [XLEN-1:0]  alu_rs2_o,
  output logic [11:0]      alu_low_imm_o,
  output logic [19:0]      alu_upper_imm_o,
  output logic [XLEN-1:0]  alu_pc_o,
  output logic [XLEN-1:0]  alu_mem_in_o,
  input  logic [XLEN-1:0]  alu_rd_i,
  input  logic [XLEN-1:0]  alu_pc_out_i,
  input  logic [XLEN-1:0]  alu_io_in_addr_i,
  input  logic [XLEN-1:0]  alu_io_out_addr_i,
  input  logic             alu_ecall_i,
  input  logic             alu_ebreak_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_req_we_o,
  output logic [1:0]       mem_req_size_o,
  output logic [XLEN-1:0]  mem_req_addr_o,
  output logic [XLEN-1:0]  mem_req_wdata_o,
  input  logic             mem_resp_valid_i,
  input  logic [XLEN-1:0]  mem_resp_data_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_idx_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             pc_valid_o,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             trap_valid_o,
  output logic [2:0]       trap_cause_o,
  output logic [XLEN-1:0]  trap_pc_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_LOAD_EXT, S_COMMIT, S_TRAP
  } state_e;

  // Group set: ALU=0 ALUI=1 ALUW=2 ALUIW=3 LUI=4 AUIPC=5 JMP=6 BNCH=7 LDST=8 SYS=9 MEM=10
  localparam logic [OPG_W-1:0] OPG_JMP  = OPG_W'(6);
  localparam logic [OPG_W-1:0] OPG_BNCH = OPG_W'(7);
  localparam logic [OPG_W-1:0] OPG_LDST = OPG_W'(8);
  localparam logic [OPG_W-1:0] OPG_SYS  = OPG_W'(9);
  localparam logic [OPG_W-1:0] OPG_MEM  = OPG_W'(10);

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LWU = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SD  = OP_W'(11);

  localparam logic [2:0] CAUSE_ECALL    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK   = 3'd1;
  localparam logic [2:0] CAUSE_TIMEOUT  = 3'd2;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd3;
  localparam logic [2:0] CAUSE_ILLEGAL  = 3'd4;
  localparam logic [7:0] TMO_LAST       = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [OPG_W-1:0] group_q, group_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, mem_in_q, mem_in_d;
  logic [11:0]      imm_q, imm_d;
  logic [19:0]      uimm_q, uimm_d;
  logic [4:0]       rd_idx_q, rd_idx_d;
  logic             wb_en_q, wb_en_d;
  logic [XLEN-1:0]  result_q, result_d, next_pc_q, next_pc_d;
  logic [XLEN-1:0]  maddr_q, maddr_d, wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic [2:0]       cause_q, cause_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             ls_store, ls_legal, misaligned;
  logic [1:0]       ls_size;
  logic [2:0]       align_mask;
  logic [XLEN-1:0]  ls_addr, pc_plus4;

  always_comb begin
    ls_store = 1'b0;
    ls_size  = 2'd0;
    ls_legal = 1'b1;
    case (op_q)
      OP_LB, OP_LBU: ls_size = 2'd0;
      OP_LH, OP_LHU: ls_size = 2'd1;
      OP_LW, OP_LWU: ls_size = 2'd2;
      OP_LD:         ls_size = 2'd3;
      OP_SB: begin ls_store = 1'b1; ls_size = 2'd0; end
      OP_SH: begin ls_store = 1'b1; ls_size = 2'd1; end
      OP_SW: begin ls_store = 1'b1; ls_size = 2'd2; end
      OP_SD: begin ls_store = 1'b1; ls_size = 2'd3; end
      default: ls_legal = 1'b0;
    endcase
  end

  assign ls_addr    = ls_store ? alu_io_out_addr_i : alu_io_in_addr_i;
  assign align_mask = (3'd1 << ls_size) - 3'd1;
  assign misaligned = |(ls_addr[2:0] & align_mask);
  assign pc_plus4   = pc_q + XLEN'(4);

  always_comb begin
    state_d   = state_q;
    group_d   = group_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    pc_d      = pc_q;
    mem_in_d  = mem_in_q;
    imm_d     = imm_q;
    uimm_d    = uimm_q;
    rd_idx_d  = rd_idx_q;
    wb_en_d   = wb_en_q;
    result_d  = result_q;
    next_pc_d = next_pc_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    size_d    = size_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid_i) begin
          group_d  = issue_op_group_i;
          op_d     = issue_op_i;
          rs1_d    = issue_rs1_i;
          rs2_d    = issue_rs2_i;
          pc_d     = issue_pc_i;
          imm_d    = issue_imm_i;
          uimm_d   = issue_uimm_i;
          rd_idx_d = issue_rd_idx_i;
          wb_en_d  = issue_wb_en_i;
          mem_in_d = '0;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (group_q > OPG_MEM || (group_q == OPG_LDST && !ls_legal)) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end else if (group_q == OPG_SYS && alu_ecall_i) begin
          cause_d = CAUSE_ECALL;
          state_d = S_TRAP;
        end else if (group_q == OPG_SYS && alu_ebreak_i) begin
          cause_d = CAUSE_EBREAK;
          state_d = S_TRAP;
        end else if (group_q == OPG_LDST) begin
          maddr_d = ls_addr;
          wdata_d = ls_store ? alu_rd_i : '0;
          we_d    = ls_store;
          size_d  = ls_size;
          if (misaligned) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_TRAP;
          end else begin
            state_d = S_MEM_REQ;
          end
        end else begin
          result_d  = alu_rd_i;
          next_pc_d = (group_q == OPG_JMP || group_q == OPG_BNCH) ? alu_pc_out_i : pc_plus4;
          state_d   = S_COMMIT;
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready_i) begin
          cnt_d   = 8'd0;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving on the final counted cycle still completes normally.
        if (mem_resp_valid_i) begin
          if (we_q) begin
            next_pc_d = pc_plus4;
            state_d   = S_COMMIT;
          end else begin
            mem_in_d = mem_resp_data_i;
            state_d  = S_LOAD_EXT;
          end
        end else if (cnt_q == TMO_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_TRAP;
        end
      end
      S_LOAD_EXT: begin
        result_d  = alu_rd_i;
        next_pc_d = pc_plus4;
        state_d   = S_COMMIT;
      end
      S_COMMIT, S_TRAP: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      group_q   <= '0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      mem_in_q  <= '0;
      imm_q     <= '0;
      uimm_q    <= '0;
      rd_idx_q  <= '0;
      wb_en_q   <= 1'b0;
      result_q  <= '0;
      next_pc_q <= '0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pc_q      <= pc_d;
      mem_in_q  <= mem_in_d;
      imm_q     <= imm_d;
      uimm_q    <= uimm_d;
      rd_idx_q  <= rd_idx_d;
      wb_en_q   <= wb_en_d;
      result_q  <= result_d;
      next_pc_q <= next_pc_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      size_q    <= size_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign issue_ready_o   = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign alu_op_group_o  = group_q;
  assign alu_op_o        = op_q;
  assign alu_rs1_o       = rs1_q;
  assign alu_rs2_o       = rs2_q;
  assign alu_low_imm_o   = imm_q;
  assign alu_upper_imm_o = uimm_q;
  assign alu_pc_o        = pc_q;
  assign alu_mem_in_o    = mem_in_q;
  assign mem_req_valid_o = (state_q == S_MEM_REQ);
  assign mem_req_we_o    = we_q;
  assign mem_req_size_o  = size_q;
  assign mem_req_addr_o  = maddr_q;
  assign mem_req_wdata_o = wdata_q;
  // Branches, fences and stores never write a register, nor does x0.
  assign wb_valid_o      = (state_q == S_COMMIT) && wb_en_q && (rd_idx_q != 5'd0) &&
                           (group_q != OPG_BNCH) && (group_q != OPG_MEM) &&
                           !(group_q == OPG_LDST && ls_store);
  assign wb_rd_idx_o     = rd_idx_q;
  assign wb_data_o       = result_q;
  assign pc_valid_o      = (state_q == S_COMMIT);
  assign pc_next_o       = next_pc_q;
  assign trap_valid_o    = (state_q == S_TRAP);
  assign trap_cause_o    = cause_q;
  assign trap_pc_o       = pc_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a small behavioural ALU model and
// manually driven memory handshake.
module tb_alu_exec_sequencer;
  localparam logic [3:0] G_ALUI = 4'd1, G_JMP = 4'd6, G_BNCH = 4'd7, G_LDST = 4'd8, G_SYS = 4'd9;
  localparam logic [5:0] OP_LB = 6'd0, OP_LD = 6'd3, OP_SW = 6'd10, OP_SD = 6'd11;

  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid, issue_ready, issue_wb_en;
  logic [3:0] issue_op_group;
  logic [5:0] issue_op;
  logic [63:0] issue_rs1, issue_rs2, issue_pc;
  logic [11:0] issue_imm;
  logic [19:0] issue_uimm;
  logic [4:0] issue_rd_idx;
  logic [3:0] alu_op_group;
  logic [5:0] alu_op;
  logic [63:0] alu_rs1, alu_rs2, alu_pc, alu_mem_in;
  logic [11:0] alu_low_imm;
  logic [19:0] alu_upper_imm;
  logic [63:0] m_rd, m_pc_out, m_in_addr, m_out_addr, sext_imm;
  logic m_ecall, m_ebreak;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [1:0] mem_req_size;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic wb_valid, pc_valid, trap_valid, busy;
  logic [4:0] wb_rd_idx;
  logic [63:0] wb_data, pc_next, trap_pc;
  logic [2:0] trap_cause;

  int n_tests = 0, n_fail = 0;
  int wb_cnt = 0, pc_cnt = 0, trap_cnt = 0, req_cnt = 0;
  int w0, p0, t0, r0, n;

  always #5 clk = ~clk;

  alu_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_op_group_i(issue_op_group), .issue_op_i(issue_op),
    .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_pc_i(issue_pc),
    .issue_imm_i(issue_imm), .issue_uimm_i(issue_uimm),
    .issue_rd_idx_i(issue_rd_idx), .issue_wb_en_i(issue_wb_en),
    .alu_op_group_o(alu_op_group), .alu_op_o(alu_op),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2),
    .alu_low_imm_o(alu_low_imm), .alu_upper_imm_o(alu_upper_imm),
    .alu_pc_o(alu_pc), .alu_mem_in_o(alu_mem_in),
    .alu_rd_i(m_rd), .alu_pc_out_i(m_pc_out),
    .alu_io_in_addr_i(m_in_addr), .alu_io_out_addr_i(m_out_addr),
    .alu_ecall_i(m_ecall), .alu_ebreak_i(m_ebreak),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_we_o(mem_req_we), .mem_req_size_o(mem_req_size),
    .mem_req_addr_o(mem_req_addr), .mem_req_wdata_o(mem_req_wdata),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_data_i(mem_resp_data),
    .wb_valid_o(wb_valid), .wb_rd_idx_o(wb_rd_idx), .wb_data_o(wb_data),
    .pc_valid_o(pc_valid), .pc_next_o(pc_next),
    .trap_valid_o(trap_valid), .trap_cause_o(trap_cause), .trap_pc_o(trap_pc),
    .busy_o(busy)
  );

  // Behavioural ALU covering only the ops this bench issues.
  always_comb begin
    m_rd = '0; m_pc_out = '0; m_in_addr = '0; m_out_addr = '0;
    m_ecall = 1'b0; m_ebreak = 1'b0;
    sext_imm = {{52{alu_low_imm[11]}}, alu_low_imm};
    case (alu_op_group)
      G_ALUI: m_rd = alu_rs1 + sext_imm;
      G_JMP: begin m_rd = alu_pc + 64'd4; m_pc_out = alu_pc + sext_imm; end
      G_BNCH: m_pc_out = alu_pc + sext_imm;
      G_LDST: begin
        m_in_addr = alu_rs1 + sext_imm;
        m_out_addr = alu_rs1 + sext_imm;
        case (alu_op)
          OP_LB: m_rd = {{56{alu_mem_in[7]}}, alu_mem_in[7:0]};
          OP_SW: m_rd = {32'd0, alu_rs2[31:0]};
          OP_SD: m_rd = alu_rs2;
          default: m_rd = alu_mem_in;
        endcase
      end
      G_SYS: begin m_ecall = (alu_op == 6'd0); m_ebreak = (alu_op == 6'd1); end
      default: m_rd = '0;
    endcase
  end

  always @(negedge clk) begin
    if (wb_valid) wb_cnt <= wb_cnt + 1;
    if (pc_valid) pc_cnt <= pc_cnt + 1;
    if (trap_valid) trap_cnt <= trap_cnt + 1;
    if (mem_req_valid) req_cnt <= req_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] grp, input logic [5:0] op, input logic [63:0] rs1,
                           input logic [63:0] rs2, input logic [63:0] pc, input logic [11:0] imm,
                           input logic [4:0] rd, input logic wb_en);
    issue_op_group = grp; issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_pc = pc; issue_imm = imm; issue_uimm = 20'd0; issue_rd_idx = rd; issue_wb_en = wb_en;
  endtask

  // Presents one instruction, returns in the EXEC cycle.
  task automatic issue(input logic [3:0] grp, input logic [5:0] op, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] pc, input logic [11:0] imm,
                       input logic [4:0] rd, input logic wb_en);
    set_issue(grp, op, rs1, rs2, pc, imm, rd, wb_en);
    issue_valid = 1'b1;
    chk("issue_ready", issue_ready, 1'b1);
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    issue_valid = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    set_issue(4'd0, 6'd0, '0, '0, '0, '0, 5'd0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_alu_rs1", alu_rs1, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // ADDI x3 = 5 + (-1)
    issue(G_ALUI, 6'd0, 64'd5, 64'd0, 64'h1000, 12'hFFF, 5'd3, 1'b1);
    chk("addi_busy", busy, 1'b1);
    chk("addi_exec_no_wb", wb_valid, 1'b0);
    step();
    chk("addi_wb_valid", wb_valid, 1'b1);
    chk("addi_wb_rd", wb_rd_idx, 5'd3);
    chk("addi_wb_data", wb_data, 64'd4);
    chk("addi_pc_valid", pc_valid, 1'b1);
    chk("addi_pc_next", pc_next, 64'h1004);
    step();
    chk("addi_idle", issue_ready, 1'b1);

    // pc+4 wraps modulo 2^64
    issue(G_ALUI, 6'd0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 12'd2, 5'd6, 1'b1);
    step();
    chk("wrap_pc_next", pc_next, 64'd0);
    chk("wrap_wb_data", wb_data, 64'd3);
    step();

    // JAL: next PC comes from the ALU
    issue(G_JMP, 6'd0, 64'd0, 64'd0, 64'h100, 12'h020, 5'd1, 1'b1);
    step();
    chk("jal_wb_data", wb_data, 64'h104);
    chk("jal_pc_next", pc_next, 64'h120);
    step();

    // Branch never writes back
    issue(G_BNCH, 6'd0, 64'd0, 64'd0, 64'h200, 12'hFF0, 5'd5, 1'b1);
    step();
    chk("bnch_no_wb", wb_valid, 1'b0);
    chk("bnch_pc_next", pc_next, 64'h1F0);
    step();

    // LB with delayed ready and a stray response during MEM_REQ
    issue(G_LDST, OP_LB, 64'h1000, 64'd0, 64'h2000, 12'd2, 5'd5, 1'b1);
    step();
    chk("lb_req_valid", mem_req_valid, 1'b1);
    chk("lb_addr", mem_req_addr, 64'h1002);
    chk("lb_size", mem_req_size, 2'd0);
    chk("lb_we", mem_req_we, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD;
    step();
    chk("lb_req_hold", mem_req_valid, 1'b1);
    chk("lb_addr_hold", mem_req_addr, 64'h1002);
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("lb_wait_req_low", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h80;
    step();
    mem_resp_valid = 1'b0;
    chk("lb_mem_in", alu_mem_in, 64'h80);
    step();
    chk("lb_wb_valid", wb_valid, 1'b1);
    chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_pc_next", pc_next, 64'h2004);
    step();

    // Misaligned SD traps before any memory request
    w0 = wb_cnt; r0 = req_cnt; p0 = pc_cnt;
    issue(G_LDST, OP_SD, 64'h1000, 64'd7, 64'h3000, 12'd4, 5'd2, 1'b1);
    step();
    chk("sd_trap_valid", trap_valid, 1'b1);
    chk("sd_trap_cause", trap_cause, 3'd3);
    chk("sd_trap_pc", trap_pc, 64'h3000);
    step();
    chk("sd_no_req", req_cnt - r0, 0);
    chk("sd_no_wb", wb_cnt - w0, 0);
    chk("sd_no_pc", pc_cnt - p0, 0);

    // SW with immediate ack
    w0 = wb_cnt;
    issue(G_LDST, OP_SW, 64'h2000, 64'h1122334455667788, 64'h4000, 12'd0, 5'd7, 1'b1);
    step();
    chk("sw_we", mem_req_we, 1'b1);
    chk("sw_size", mem_req_size, 2'd2);
    chk("sw_addr", mem_req_addr, 64'h2000);
    chk("sw_wdata", mem_req_wdata, 64'h55667788);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("sw_pc_valid", pc_valid, 1'b1);
    chk("sw_pc_next", pc_next, 64'h4004);
    step();
    chk("sw_no_wb", wb_cnt - w0, 0);

    // Load timeout with no response
    issue(G_LDST, OP_LD, 64'h3000, 64'd0, 64'h5000, 12'd0, 5'd9, 1'b1);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    n = 0;
    while (!trap_valid && n < 400) begin step(); n++; end
    chk("tmo_cycles", 64'(n), 64'd255);
    chk("tmo_cause", trap_cause, 3'd2);
    chk("tmo_pc", trap_pc, 64'h5000);
    step();

    // Response on the last counted cycle wins
    t0 = trap_cnt;
    issue(G_LDST, OP_LD, 64'h3000, 64'd0, 64'h5100, 12'd0, 5'd9, 1'b1);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (254) step();
    chk("tmo_edge_busy", busy, 1'b1);
    chk("tmo_edge_no_trap", trap_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h0123456789ABCDEF;
    step();
    mem_resp_valid = 1'b0;
    step();
    chk("tmo_edge_wb", wb_valid, 1'b1);
    chk("tmo_edge_data", wb_data, 64'h0123456789ABCDEF);
    chk("tmo_edge_no_trap_cnt", trap_cnt - t0, 0);
    step();

    // Back-to-back issue with valid held high; second targets x0
    set_issue(G_ALUI, 6'd0, 64'd10, 64'd0, 64'h800, 12'd5, 5'd4, 1'b1);
    issue_valid = 1'b1;
    step();
    step();
    chk("b2b_first_wb", wb_data, 64'd15);
    set_issue(G_ALUI, 6'd0, 64'd7, 64'd0, 64'h900, 12'd1, 5'd0, 1'b1);
    step();
    chk("b2b_idle_gap", busy, 1'b0);
    step();
    chk("b2b_reaccept", busy, 1'b1);
    issue_valid = 1'b0;
    step();
    chk("b2b_x0_no_wb", wb_valid, 1'b0);
    chk("b2b_pc_next", pc_next, 64'h904);
    step();

    // Reset asserted during MEM_REQ abandons the load
    issue(G_LDST, OP_LD, 64'h100, 64'd0, 64'h6000, 12'd0, 5'd8, 1'b1);
    step();
    chk("rstmid_req_valid", mem_req_valid, 1'b1);
    w0 = wb_cnt; p0 = pc_cnt; t0 = trap_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_req_drop", mem_req_valid, 1'b0);
    chk("rstmid_ready", issue_ready, 1'b1);
    chk("rstmid_rs1_clr", alu_rs1, 64'd0);
    step();
    rst_n = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    repeat (3) step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("rstmid_no_pulses", 64'((wb_cnt - w0) + (pc_cnt - p0) + (trap_cnt - t0)), 64'd0);

    // ECALL and illegal group after reset
    issue(G_SYS, 6'd0, 64'd0, 64'd0, 64'h7000, 12'd0, 5'd0, 1'b0);
    step();
    chk("ecall_trap", trap_valid, 1'b1);
    chk("ecall_cause", trap_cause, 3'd0);
    chk("ecall_pc", trap_pc, 64'h7000);
    chk("ecall_no_pc", pc_valid, 1'b0);
    step();
    issue(G_SYS, 6'd1, 64'd0, 64'd0, 64'h7100, 12'd0, 5'd0, 1'b0);
    step();
    chk("ebreak_cause", trap_cause, 3'd1);
    step();
    issue(4'hF, 6'd0, 64'd0, 64'd0, 64'h7200, 12'd0, 5'd3, 1'b1);
    step();
    chk("illegal_trap", trap_valid, 1'b1);
    chk("illegal_cause", trap_cause, 3'd4);
    chk("illegal_no_wb", wb_valid, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
